// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity-mode constants and the
// default bit period used by both uart_tx and uart_rx.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Host-side handshake and serial line of the UART transmitter.
interface uart_tx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_out;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (output tx_start, tx_data, input tx_out, tx_busy, tx_done);
  modport slave  (input tx_start, tx_data, output tx_out, tx_busy, tx_done);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, flags the last
// cycle of each bit period, and parks at zero when disabled.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick_c = en && (cnt == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!en || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit(s).
// All outputs are registered; the line idles high.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic    clock,
  input  logic    reset,
  uart_tx_if.slave bus
);

  localparam int unsigned DW = $clog2(DATA_BITS + 1);
  localparam logic [DW-1:0] LAST_IDX = DW'(DATA_BITS - 1);
  localparam logic [0:0] STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
  localparam logic HAS_PAR = (PARITY_EN != 0);

  uart_state_e state, state_nxt;

  logic [DATA_BITS-1:0] sreg, sreg_d;
  logic [DW-1:0]        bit_idx, bit_idx_d;
  logic [0:0]           stop_idx, stop_idx_d;
  logic                 par_bit, par_bit_d;
  logic                 tx_out_q, tx_out_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 tick_c;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clock  (clock),
    .reset  (reset),
    .en     (state != ST_IDLE),
    .tick_c (tick_c)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (bus.tx_start) state_nxt = ST_START;
      ST_START:  if (tick_c) state_nxt = ST_DATA;
      ST_DATA:   if (tick_c && (bit_idx == LAST_IDX)) state_nxt = HAS_PAR ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick_c) state_nxt = ST_STOP;
      ST_STOP:   if (tick_c && (stop_idx == STOP_LAST)) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the datapath and output registers
  always_comb begin
    sreg_d     = sreg;
    bit_idx_d  = bit_idx;
    stop_idx_d = stop_idx;
    par_bit_d  = par_bit;
    tx_out_d   = tx_out_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        tx_out_d = 1'b1;
        busy_d   = 1'b0;
        if (bus.tx_start) begin
          sreg_d     = bus.tx_data;
          par_bit_d  = (^bus.tx_data) ^ PAR_MODE;
          bit_idx_d  = '0;
          stop_idx_d = '0;
          tx_out_d   = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_START: begin
        if (tick_c) begin
          tx_out_d = sreg[0];
          sreg_d   = {1'b0, sreg[DATA_BITS-1:1]};
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          if (bit_idx == LAST_IDX) begin
            tx_out_d = HAS_PAR ? par_bit : 1'b1;
          end else begin
            bit_idx_d = bit_idx + DW'(1);
            tx_out_d  = sreg[0];
            sreg_d    = {1'b0, sreg[DATA_BITS-1:1]};
          end
        end
      end
      ST_PARITY: begin
        if (tick_c) tx_out_d = 1'b1;
      end
      ST_STOP: begin
        if (tick_c) begin
          if (stop_idx == STOP_LAST) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            stop_idx_d = stop_idx + 1'b1;
          end
        end
      end
      default: begin
        tx_out_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sreg     <= '0;
      bit_idx  <= '0;
      stop_idx <= '0;
      par_bit  <= 1'b0;
      tx_out_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      sreg     <= sreg_d;
      bit_idx  <= bit_idx_d;
      stop_idx <= stop_idx_d;
      par_bit  <= par_bit_d;
      tx_out_q <= tx_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.tx_out  = tx_out_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one even-parity and one odd-parity instance,
// per-cycle line capture compared against hand-built frames.
module tb_uart_tx;
  import uart_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  uart_tx_if #(.DATA_BITS(8)) be ();
  uart_tx_if #(.DATA_BITS(8)) bo ();

  uart_tx #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_e (
    .clock (clock),
    .reset (reset),
    .bus   (be)
  );

  uart_tx #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_o (
    .clock (clock),
    .reset (reset),
    .bus   (bo)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Frame vector {stop, parity, data[7:0], start}, each bit stretched to 8 cycles
  function automatic logic [87:0] expand(input logic [10:0] f);
    logic [87:0] w;
    for (int i = 0; i < 88; i++) w[i] = f[i/8];
    return w;
  endfunction

  // Records line/busy/done after each of the 88 edges following an accept
  task automatic capture(input bit sel, output logic [87:0] w, output logic [87:0] b,
                         output logic [87:0] d);
    for (int i = 0; i < 88; i++) begin
      @(negedge clock);
      w[i] = sel ? bo.tx_out  : be.tx_out;
      b[i] = sel ? bo.tx_busy : be.tx_busy;
      d[i] = sel ? bo.tx_done : be.tx_done;
    end
  endtask

  // Presents tx_start for the next edge; returns 1 ns after the accept edge
  task automatic start_frame(input bit sel, input logic [7:0] data, input bit hold);
    @(posedge clock); #1;
    if (sel) begin bo.tx_start = 1'b1; bo.tx_data = data; end
    else     begin be.tx_start = 1'b1; be.tx_data = data; end
    @(posedge clock); #1;
    if (!hold) begin
      if (sel) bo.tx_start = 1'b0;
      else     be.tx_start = 1'b0;
    end
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b0;
    be.tx_start = 1'b0; be.tx_data = '0;
    bo.tx_start = 1'b0; bo.tx_data = '0;
    #12;
    cmp_cnt++;
    if ({be.tx_out, be.tx_busy, be.tx_done} !== 3'b100) begin
      err_cnt++;
      $display("FAIL reset_hold: got %b want 100", {be.tx_out, be.tx_busy, be.tx_done});
    end
    #8 reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if ({be.tx_out, be.tx_busy, be.tx_done, bo.tx_out, bo.tx_busy, bo.tx_done} !== 6'b100100) bad++;
    end
    cmp_cnt++;
    if (bad != 0) begin
      err_cnt++;
      $display("FAIL reset_idle: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_single_frame();
    logic [87:0] w, b, d;
    logic [7:0]  rx;
    start_frame(0, 8'hED, 0);
    capture(0, w, b, d);
    cmp_cnt++;
    if (w !== expand(11'b1_0_11101101_0)) begin
      err_cnt++;
      $display("FAIL single_wave: got %h want %h", w, expand(11'b1_0_11101101_0));
    end
    cmp_cnt++;
    if (b !== {88{1'b1}}) begin
      err_cnt++;
      $display("FAIL single_busy: got %h want all ones", b);
    end
    cmp_cnt++;
    if (d !== 88'h0) begin
      err_cnt++;
      $display("FAIL single_done_early: got %h want 0", d);
    end
    for (int k = 0; k < 8; k++) rx[k] = w[8*(k+1)+4];
    cmp_cnt++;
    if (rx !== 8'hED) begin
      err_cnt++;
      $display("FAIL single_decode: got %h want ed", rx);
    end
    @(negedge clock);
    cmp_cnt++;
    if ({be.tx_done, be.tx_busy, be.tx_out} !== 3'b101) begin
      err_cnt++;
      $display("FAIL single_done_pulse: got %b want 101", {be.tx_done, be.tx_busy, be.tx_out});
    end
    @(negedge clock);
    cmp_cnt++;
    if (be.tx_done !== 1'b0) begin
      err_cnt++;
      $display("FAIL single_done_width: got %b want 0", be.tx_done);
    end
  endtask

  task automatic test_parity();
    logic [87:0] w, b, d;
    start_frame(1, 8'h00, 0);
    capture(1, w, b, d);
    cmp_cnt++;
    if (w !== expand(11'b1_1_00000000_0)) begin
      err_cnt++;
      $display("FAIL odd_wave: got %h want %h", w, expand(11'b1_1_00000000_0));
    end
    cmp_cnt++;
    if (w[76] !== 1'b1) begin
      err_cnt++;
      $display("FAIL odd_parity_bit: got %b want 1", w[76]);
    end
    start_frame(0, 8'h01, 0);
    capture(0, w, b, d);
    cmp_cnt++;
    if (w !== expand(11'b1_1_00000001_0)) begin
      err_cnt++;
      $display("FAIL even01_wave: got %h want %h", w, expand(11'b1_1_00000001_0));
    end
    cmp_cnt++;
    if (w[76] !== 1'b1) begin
      err_cnt++;
      $display("FAIL even01_parity_bit: got %b want 1", w[76]);
    end
  endtask

  task automatic test_busy_reject();
    logic [87:0] w, b, d;
    int bad;
    start_frame(0, 8'hAA, 0);
    fork
      capture(0, w, b, d);
      begin
        repeat (29) @(posedge clock);
        #1 be.tx_start = 1'b1; be.tx_data = 8'h55;
        @(posedge clock);
        #1 be.tx_start = 1'b0;
      end
    join
    cmp_cnt++;
    if (w !== expand(11'b1_0_10101010_0)) begin
      err_cnt++;
      $display("FAIL reject_wave: got %h want %h", w, expand(11'b1_0_10101010_0));
    end
    @(negedge clock);
    cmp_cnt++;
    if ({be.tx_done, be.tx_busy, be.tx_out} !== 3'b101) begin
      err_cnt++;
      $display("FAIL reject_done: got %b want 101", {be.tx_done, be.tx_busy, be.tx_out});
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if ({be.tx_done, be.tx_busy, be.tx_out} !== 3'b001) bad++;
    end
    cmp_cnt++;
    if (bad != 0) begin
      err_cnt++;
      $display("FAIL reject_no_queue: got %0d non-idle cycles want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [87:0] w1, b1, d1, w2, b2, d2;
    int bad;
    start_frame(0, 8'h3C, 1);
    fork
      capture(0, w1, b1, d1);
      begin
        repeat (9) @(posedge clock);
        #1 be.tx_data = 8'hC3;
      end
    join
    cmp_cnt++;
    if (w1 !== expand(11'b1_0_00111100_0)) begin
      err_cnt++;
      $display("FAIL b2b_first_wave: got %h want %h", w1, expand(11'b1_0_00111100_0));
    end
    @(negedge clock);
    cmp_cnt++;
    if ({be.tx_done, be.tx_busy, be.tx_out} !== 3'b101) begin
      err_cnt++;
      $display("FAIL b2b_done: got %b want 101", {be.tx_done, be.tx_busy, be.tx_out});
    end
    fork
      capture(0, w2, b2, d2);
      begin
        repeat (3) @(posedge clock);
        #1 be.tx_start = 1'b0;
      end
    join
    cmp_cnt++;
    if ({w2[0], b2[0]} !== 2'b01) begin
      err_cnt++;
      $display("FAIL b2b_no_gap: got out/busy %b want 01", {w2[0], b2[0]});
    end
    cmp_cnt++;
    if (w2 !== expand(11'b1_0_11000011_0)) begin
      err_cnt++;
      $display("FAIL b2b_second_wave: got %h want %h", w2, expand(11'b1_0_11000011_0));
    end
    @(negedge clock);
    bad = ({be.tx_done, be.tx_busy} !== 2'b10) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if ({be.tx_done, be.tx_busy, be.tx_out} !== 3'b001) bad++;
    end
    cmp_cnt++;
    if (bad != 0) begin
      err_cnt++;
      $display("FAIL b2b_end: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    logic [87:0] w, b, d;
    start_frame(0, 8'h00, 0);
    repeat (8 + 8*3 + 2) @(posedge clock);
    #2;
    cmp_cnt++;
    if ({be.tx_out, be.tx_busy} !== 2'b01) begin
      err_cnt++;
      $display("FAIL mid_pre_reset: got %b want 01", {be.tx_out, be.tx_busy});
    end
    #1 reset = 1'b0;
    #1;
    cmp_cnt++;
    if ({be.tx_out, be.tx_busy, be.tx_done} !== 3'b100) begin
      err_cnt++;
      $display("FAIL mid_async_reset: got %b want 100", {be.tx_out, be.tx_busy, be.tx_done});
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    cmp_cnt++;
    if ({be.tx_out, be.tx_busy, be.tx_done} !== 3'b100) begin
      err_cnt++;
      $display("FAIL mid_idle_after: got %b want 100", {be.tx_out, be.tx_busy, be.tx_done});
    end
    start_frame(0, 8'hED, 0);
    capture(0, w, b, d);
    cmp_cnt++;
    if (w !== expand(11'b1_0_11101101_0)) begin
      err_cnt++;
      $display("FAIL mid_clean_frame: got %h want %h", w, expand(11'b1_0_11101101_0));
    end
    @(negedge clock);
    cmp_cnt++;
    if ({be.tx_done, be.tx_busy, be.tx_out} !== 3'b101) begin
      err_cnt++;
      $display("FAIL mid_clean_done: got %b want 101", {be.tx_done, be.tx_busy, be.tx_out});
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity();
    test_busy_reject();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
